invchain_delay_cal_ctrl: RTL

//  Calibration/tracking controller for a tunable delay line built from a chain of inverter cells.

---
 rtl/invchain_delay_cal_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/invchain_delay_cal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : invchain_delay_cal_ctrl
//  Purpose  : Calibration and tracking controller for an inverter-chain delay
//             line. Sweeps the tap select upward, votes on a synchronized
//             phase-detector flag after each step and locks on the first tap
//             that is no longer early. Optionally tracks drift after lock.
//  Revision : 1.0 - initial release
// ============================================================================
module invchain_delay_cal_ctrl #(
    parameter int TAP_W       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int VOTE_N      = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             track_en_i,
    input  logic             pd_early_i,
    output logic             dl_en_o,
    output logic [TAP_W-1:0] tap_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             locked_o,
    output logic             err_o
);

    // The synchronizer latency must be covered by the settle wait.
    localparam int SETTLE_EFF = (SETTLE_CYC > SYNC_STAGES) ? SETTLE_CYC : SYNC_STAGES;
    localparam int CNT_MAX    = (SETTLE_EFF > VOTE_N) ? SETTLE_EFF : VOTE_N;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int ONES_W     = $clog2(VOTE_N + 1);

    localparam logic [TAP_W-1:0]  TAP_MAX     = '1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [CNT_W-1:0]  VOTE_LAST   = CNT_W'(VOTE_N - 1);
    localparam logic [ONES_W-1:0] VOTE_ALL    = ONES_W'(VOTE_N);
    localparam logic [ONES_W-1:0] VOTE_HALF   = ONES_W'(VOTE_N / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_STEP   = 3'd3,
        S_LOCK   = 3'd4,
        S_TRACK  = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [ONES_W-1:0]      ones_q,   ones_d;
    logic                   trk_q,    trk_d;      // current window uses tracking rules
    logic [TAP_W-1:0]       tap_q,    tap_d;
    logic                   dl_en_q,  dl_en_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic                   locked_q, locked_d;
    logic                   err_q,    err_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   pd_s;
    logic [ONES_W-1:0]      ones_now;

    assign pd_s     = sync_q[SYNC_STAGES-1];
    assign ones_now = ones_q + ONES_W'(pd_s);

    // Next-state logic: sweep, vote, lock/fail and post-lock tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        trk_d    = trk_q;
        tap_d    = tap_q;
        dl_en_d  = dl_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        locked_d = locked_q;
        err_d    = err_q;

        // START is honoured whenever no sweep is running (IDLE, LOCK, TRACK, FAIL).
        if (start_i && !busy_q) begin
            state_d  = S_SETTLE;
            cnt_d    = '0;
            ones_d   = '0;
            trk_d    = 1'b0;
            tap_d    = '0;
            dl_en_d  = 1'b1;
            busy_d   = 1'b1;
            locked_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_SAMPLE;
                        cnt_d   = '0;
                        ones_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (cnt_q == VOTE_LAST) begin
                        cnt_d  = '0;
                        ones_d = '0;
                        if (trk_q) begin
                            // Tracking moves only on a unanimous vote, saturating.
                            state_d = S_TRACK;
                            if ((ones_now == VOTE_ALL) && (tap_q != TAP_MAX)) begin
                                tap_d = tap_q + 1'b1;
                            end else if ((ones_now == '0) && (tap_q != '0)) begin
                                tap_d = tap_q - 1'b1;
                            end
                        end else if (ones_now > VOTE_HALF) begin
                            if (tap_q == TAP_MAX) begin
                                state_d = S_FAIL;
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = S_STEP;
                            end
                        end else begin
                            state_d  = S_LOCK;
                            done_d   = 1'b1;
                            locked_d = 1'b1;
                            busy_d   = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        ones_d = ones_now;
                    end
                end
                S_STEP: begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
                S_LOCK: begin
                    if (track_en_i) begin
                        state_d = S_TRACK;
                    end
                end
                S_TRACK: begin
                    // Window boundary: either start another window or fall back to LOCK.
                    if (track_en_i) begin
                        state_d = S_SETTLE;
                        trk_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_LOCK;
                        trk_d   = 1'b0;
                    end
                end
                S_IDLE, S_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, registered outputs and the PD_EARLY synchronizer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            trk_q    <= 1'b0;
            tap_q    <= '0;
            dl_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            trk_q    <= trk_d;
            tap_q    <= tap_d;
            dl_en_q  <= dl_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pd_early_i};
        end
    end

    assign dl_en_o   = dl_en_q;
    assign tap_sel_o = tap_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire
